// File: rtl/bcd_operand_frontend_pkg.sv
// Shared constants for the BCD operand front end: default operand width
// and active-low 7-segment codes ({dp,g,f,e,d,c,b,a}).
package bcd_operand_frontend_pkg;

  localparam int INPUTWIDTH = 16;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [3:0] ANODE_OFF = 4'hF;

endpackage

// File: rtl/bcd_operand_frontend_seg7_decode.sv
// Combinational BCD digit to active-low segment code; non-decimal
// digit values render as a dash so bad input is visible on the display.
module bcd_seg7_decode
  import bcd_operand_frontend_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_MINUS;
    case (digit_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_MINUS;
    endcase
  end

endmodule

// File: rtl/bcd_operand_frontend.sv
// Calculator operand front end: two-stage BCD->signed binary converter
// loading operand A/B, plus a multiplexed 4-digit 7-segment scanner.
module bcd_operand_frontend
  import bcd_operand_frontend_pkg::*;
#(
  parameter int N           = INPUTWIDTH,
  parameter int REFRESH_DIV = 100000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [3:0]   hundreds,
  input  logic [3:0]   tens,
  input  logic [3:0]   ones,
  input  logic         is_signed,
  input  logic         i_ce,
  input  logic         a,
  input  logic         b,
  output logic [N-1:0] o_bin_a,
  output logic [N-1:0] o_bin_b,
  output logic         o_bcd_err,
  input  logic         i_disp_ce,
  input  logic [11:0]  i_bcd,
  output logic [3:0]   led_active,
  output logic [7:0]   led_code
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  // Converter stage 1: magnitude, sign, targets and digit validity
  logic         s1_valid_q, s1_neg_q, s1_a_q, s1_b_q, s1_err_q;
  logic [9:0]   s1_mag_q;
  logic [9:0]   mag_d;
  logic         err_d;
  logic [N-1:0] mag_ext, val_d;
  logic [N-1:0] bin_a_q, bin_b_q;
  logic         bcd_err_q;

  // Out-of-range digits may overflow 10 bits, but such a result is discarded.
  assign mag_d   = 10'(hundreds) * 10'd100 + 10'(tens) * 10'd10 + 10'(ones);
  assign err_d   = (hundreds > 4'd9) | (tens > 4'd9) | (ones > 4'd9);
  assign mag_ext = N'(s1_mag_q);
  assign val_d   = s1_neg_q ? (~mag_ext + N'(1)) : mag_ext;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1_valid_q <= 1'b0;
      s1_neg_q   <= 1'b0;
      s1_a_q     <= 1'b0;
      s1_b_q     <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_mag_q   <= '0;
      bin_a_q    <= '0;
      bin_b_q    <= '0;
      bcd_err_q  <= 1'b0;
    end else begin
      s1_valid_q <= i_ce;
      if (i_ce) begin
        s1_mag_q <= mag_d;
        s1_neg_q <= is_signed;
        s1_a_q   <= a;
        s1_b_q   <= b;
        s1_err_q <= err_d;
      end
      if (s1_valid_q) begin
        if (s1_err_q) begin
          bcd_err_q <= 1'b1;
        end else begin
          bcd_err_q <= 1'b0;
          if (s1_a_q) bin_a_q <= val_d;
          if (s1_b_q) bin_b_q <= val_d;
        end
      end
    end
  end

  assign o_bin_a   = bin_a_q;
  assign o_bin_b   = bin_b_q;
  assign o_bcd_err = bcd_err_q;

  // Display scanner: free-running slot counter, index advances on wrap
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic          wrap;
  logic [3:0]    digit_sel;
  logic [7:0]    seg_dec;
  logic [7:0]    code_d;
  logic [3:0]    anode_d;
  logic [3:0]    led_active_q;
  logic [7:0]    led_code_q;

  assign wrap = (cnt_q == CW'(REFRESH_DIV - 1));

  always_comb begin
    digit_sel = 4'h0;
    case (idx_q)
      2'd0:    digit_sel = i_bcd[3:0];
      2'd1:    digit_sel = i_bcd[7:4];
      2'd2:    digit_sel = i_bcd[11:8];
      default: digit_sel = 4'h0;
    endcase
  end

  bcd_seg7_decode u_dec (
    .digit_i (digit_sel),
    .seg_o   (seg_dec)
  );

  always_comb begin
    anode_d = ANODE_OFF;
    code_d  = SEG_BLANK;
    if (i_disp_ce) begin
      anode_d = ~(4'b0001 << idx_q);
      if (idx_q == 2'd3) code_d = is_signed ? SEG_MINUS : SEG_BLANK;
      else               code_d = seg_dec;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      led_active_q <= ANODE_OFF;
      led_code_q   <= SEG_BLANK;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + CW'(1);
      if (wrap) idx_q <= idx_q + 2'd1;
      led_active_q <= anode_d;
      led_code_q   <= code_d;
    end
  end

  assign led_active = led_active_q;
  assign led_code   = led_code_q;

endmodule

// File: tb/tb_bcd_operand_frontend.sv
// Directed bench for bcd_operand_frontend with a fast display refresh.
module tb_bcd_operand_frontend;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   hundreds, tens, ones;
  logic         is_signed, i_ce, a, b;
  logic [N-1:0] o_bin_a, o_bin_b;
  logic         o_bcd_err;
  logic         i_disp_ce;
  logic [11:0]  i_bcd;
  logic [3:0]   led_active;
  logic [7:0]   led_code;

  int checks_cnt = 0;
  int errors_cnt = 0;
  logic [11:0] exp_q[$];

  bcd_operand_frontend #(.N(N), .REFRESH_DIV(4)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .is_signed  (is_signed),
    .i_ce       (i_ce),
    .a          (a),
    .b          (b),
    .o_bin_a    (o_bin_a),
    .o_bin_b    (o_bin_b),
    .o_bcd_err  (o_bcd_err),
    .i_disp_ce  (i_disp_ce),
    .i_bcd      (i_bcd),
    .led_active (led_active),
    .led_code   (led_code)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one-cycle conversion strobe, result visible after the second edge
  task automatic convert(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                         input logic s, input logic ta, input logic tb);
    hundreds = h; tens = t; ones = o; is_signed = s; a = ta; b = tb; i_ce = 1'b1;
    tick();
    i_ce = 1'b0; a = 1'b0; b = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; hundreds = '0; tens = '0; ones = '0; is_signed = 1'b0;
    i_ce = 1'b0; a = 1'b0; b = 1'b0; i_disp_ce = 1'b0; i_bcd = '0;

    // 1. reset
    tick(); tick();
    check("rst_bin_a", 32'(o_bin_a), 32'h0);
    check("rst_bin_b", 32'(o_bin_b), 32'h0);
    check("rst_err", 32'(o_bcd_err), 32'h0);
    check("rst_anode", 32'(led_active), 32'hF);
    check("rst_code", 32'(led_code), 32'hFF);
    rst_n = 1'b1;
    tick();

    // 2. 123 into A, latency and hold
    hundreds = 4'd1; tens = 4'd2; ones = 4'd3; is_signed = 1'b0; a = 1'b1; i_ce = 1'b1;
    tick();
    i_ce = 1'b0; a = 1'b0;
    check("lat_a_stage1", 32'(o_bin_a), 32'h0);
    tick();
    check("a_123", 32'(o_bin_a), 32'd123);
    check("b_untouched", 32'(o_bin_b), 32'h0);
    tick(); tick();
    check("a_hold", 32'(o_bin_a), 32'd123);

    // 3. signed into B, negative zero
    convert(4'd9, 4'd9, 4'd9, 1'b1, 1'b0, 1'b1);
    check("b_m999", 32'(o_bin_b), 32'h0000FC19);
    check("a_keep_123", 32'(o_bin_a), 32'd123);
    convert(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    check("b_neg_zero", 32'(o_bin_b), 32'h0);

    // 4. bad digit then recovery
    convert(4'd4, 4'd10, 4'd0, 1'b0, 1'b1, 1'b0);
    check("err_set", 32'(o_bcd_err), 32'h1);
    check("err_a_keep", 32'(o_bin_a), 32'd123);
    convert(4'd0, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0);
    check("err_clr", 32'(o_bcd_err), 32'h0);
    check("a_50", 32'(o_bin_a), 32'd50);

    // both targets, then no target
    convert(4'd0, 4'd4, 4'd2, 1'b1, 1'b1, 1'b1);
    check("both_a_m42", 32'(o_bin_a), 32'h0000FFD6);
    check("both_b_m42", 32'(o_bin_b), 32'h0000FFD6);
    convert(4'd7, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
    check("none_a", 32'(o_bin_a), 32'h0000FFD6);
    check("none_b", 32'(o_bin_b), 32'h0000FFD6);

    // continuous enable tracks with 2-cycle latency
    a = 1'b1; i_ce = 1'b1; is_signed = 1'b0;
    hundreds = 4'd3; tens = 4'd1; ones = 4'd4; tick();
    hundreds = 4'd2; tens = 4'd7; ones = 4'd1; tick();
    check("track_314", 32'(o_bin_a), 32'd314);
    hundreds = 4'd0; tens = 4'd0; ones = 4'd8; tick();
    check("track_271", 32'(o_bin_a), 32'd271);
    i_ce = 1'b0; a = 1'b0; tick();
    check("track_8", 32'(o_bin_a), 32'd8);

    // 5. display scan from a known reset point
    i_disp_ce = 1'b1; i_bcd = 12'h705; is_signed = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back({4'hE, 8'h92});
    for (int k = 0; k < 4; k++) exp_q.push_back({4'hD, 8'hC0});
    for (int k = 0; k < 4; k++) exp_q.push_back({4'hB, 8'hF8});
    for (int k = 0; k < 4; k++) exp_q.push_back({4'h7, 8'hBF});
    while (exp_q.size() > 0) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      tick();
      check("scan", {20'h0, led_active, led_code}, {20'h0, e});
    end

    // 6a. display off mid-scan, counter keeps running, resume in place
    i_disp_ce = 1'b0;
    tick();
    check("off_anode", 32'(led_active), 32'hF);
    check("off_code", 32'(led_code), 32'hFF);
    tick(); tick(); tick(); tick();
    i_disp_ce = 1'b1; is_signed = 1'b0;
    tick();
    check("resume_anode", 32'(led_active), 32'hD);
    check("resume_code", 32'(led_code), 32'hC0);
    tick(); tick(); tick();
    tick();
    check("slot2_anode", 32'(led_active), 32'hB);
    tick(); tick(); tick();
    tick();
    check("sign_blank", {20'h0, led_active, led_code}, {20'h0, 4'h7, 8'hFF});

    // 6b. reset with a conversion in flight
    hundreds = 4'd3; tens = 4'd2; ones = 4'd1; is_signed = 1'b0; a = 1'b1; i_ce = 1'b1;
    tick();
    i_ce = 1'b0; a = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("inflight_a_rst", 32'(o_bin_a), 32'h0);
    check("inflight_anode", 32'(led_active), 32'hF);
    tick(); tick();
    check("inflight_dropped", 32'(o_bin_a), 32'h0);
    check("inflight_err", 32'(o_bcd_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
